// File: rtl/fp_align_frontend.sv
// Single-precision add/sub front end: orders operands by magnitude and right-aligns the smaller mantissa.
// Define FPA_STICKY_EN to build the sticky tracker; otherwise sticky is tied low.
module fp_align_frontend (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        sign_l,
  output logic        sign_s,
  output logic [7:0]  exp_l,
  output logic [23:0] man_l,
  output logic [23:0] man_s,
  output logic        eff_sub,
  output logic [1:0]  toobig,
  output logic        special
  ,output logic       sticky
);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t      state;
  logic [4:0]  cnt;

  logic        swap;
  logic [31:0] op_l, op_s;
  logic [7:0]  eexp_l, eexp_s, diff;
  logic        spec_in, far, bypass;

  function automatic logic is_special(input logic [31:0] f);
    return (f[30:23] == 8'd0 && f[22:0] == 23'd0) || (f[30:23] == 8'hFF);
  endfunction

  always_comb begin
    swap    = in2[30:0] > in1[30:0];
    op_l    = swap ? in2 : in1;
    op_s    = swap ? in1 : in2;
    eexp_l  = (op_l[30:23] == 8'd0) ? 8'd1 : op_l[30:23];
    eexp_s  = (op_s[30:23] == 8'd0) ? 8'd1 : op_s[30:23];
    diff    = eexp_l - eexp_s;
    spec_in = is_special(in1) || is_special(in2);
    far     = (diff > 8'd24) && !spec_in;
    bypass  = (diff == 8'd0) || far || spec_in;
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);

`ifdef FPA_STICKY_EN
  logic sticky_q;
  assign sticky = sticky_q;

  always_ff @(posedge clk) begin
    if (rst)
      sticky_q <= 1'b0;
    else if (state == IDLE && in_valid)
      sticky_q <= 1'b0;
    else if (state == SHIFT)
      sticky_q <= sticky_q | man_s[0];
  end
`else
  assign sticky = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 5'd0;
      sign_l  <= 1'b0;
      sign_s  <= 1'b0;
      exp_l   <= 8'd0;
      man_l   <= 24'd0;
      man_s   <= 24'd0;
      eff_sub <= 1'b0;
      toobig  <= 2'b00;
      special <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sign_l  <= op_l[31];
          sign_s  <= op_s[31];
          exp_l   <= eexp_l;
          man_l   <= {op_l[30:23] != 8'd0, op_l[22:0]};
          man_s   <= {op_s[30:23] != 8'd0, op_s[22:0]};
          eff_sub <= in1[31] ^ in2[31];
          toobig  <= {swap, far};
          special <= spec_in;
          // diff fits in 5 bits whenever the shift path is taken
          cnt     <= diff[4:0];
          state   <= bypass ? HOLD : SHIFT;
        end
        SHIFT: begin
          man_s <= man_s >> 1;
          cnt   <= cnt - 5'd1;
          if (cnt == 5'd1) state <= HOLD;
        end
        HOLD: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
